// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the 10-bit coordinate type.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test lo <= c < hi.
  function automatic logic in_window(input coord_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable; o_tc flags the last count so a slower counter can chain off it.
module wrap_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = H_TOTAL_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_count,
  output logic               o_tc
);

  coord_t count_reg;

  assign o_tc    = (count_reg == coord_t'(MODULUS - 1));
  assign o_count = count_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_reg <= '0;
    end else if (i_en) begin
      count_reg <= o_tc ? '0 : count_reg + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA sync/position generator; outputs are registered decodes of the current (h,v).
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_active,
  output logic [COORD_W-1:0]  o_x,
  output logic [COORD_W-1:0]  o_y,
  output logic                o_line_start,
  output logic                o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]         o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  coord_t h;
  coord_t v;
  logic   h_tc;

  wrap_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (1'b1),
    .o_count (h),
    .o_tc    (h_tc)
  );

  // The line counter only moves on the last pixel of each line.
  wrap_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (h_tc),
    .o_count (v),
    .o_tc    ()
  );

  logic   hsync_next, vsync_next, active_next, line_start_next, frame_start_next;
  logic   hsync_reg, vsync_reg, active_reg, line_start_reg, frame_start_reg;
  coord_t x_reg, y_reg;

  always_comb begin
    hsync_next       = !in_window(h, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    vsync_next       = !in_window(v, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    active_next      = in_window(h, 0, H_ACTIVE) && in_window(v, 0, V_ACTIVE);
    line_start_next  = (h == '0);
    frame_start_next = line_start_next && (v == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      active_reg      <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      active_reg      <= active_next;
      x_reg           <= h;
      y_reg           <= v;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_active      = active_reg;
  assign o_x           = x_reg;
  assign o_y           = y_reg;
  assign o_line_start  = line_start_reg;
  assign o_frame_start = frame_start_reg;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Counts on the same edge that raises o_frame_start, so the first frame reads 1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      frame_cnt_reg <= '0;
    end else if (frame_start_next) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_reg;
`endif

endmodule
